// File: rtl/exception_arbiter_pkg.sv
// Shared exception types, cause codes and arbiter state encoding for the commit-stage exception logic.
// Types and constants only; no latency or backpressure of its own.
package exception_arbiter_pkg;

  typedef logic [4:0] exc_code_t;

  localparam exc_code_t CODE_INT  = 5'd0;
  localparam exc_code_t CODE_MOD  = 5'd1;
  localparam exc_code_t CODE_TLBL = 5'd2;
  localparam exc_code_t CODE_TLBS = 5'd3;
  localparam exc_code_t CODE_ADEL = 5'd4;
  localparam exc_code_t CODE_ADES = 5'd5;
  localparam exc_code_t CODE_SYS  = 5'd8;
  localparam exc_code_t CODE_BP   = 5'd9;
  localparam exc_code_t CODE_RI   = 5'd10;
  localparam exc_code_t CODE_CPU  = 5'd11;
  localparam exc_code_t CODE_OV   = 5'd12;
  localparam exc_code_t CODE_TR   = 5'd13;

  // _if flags come from fetch, _ld/_st flags from the data side
  typedef struct packed {
    logic adel_if;
    logic tlbl_if;
    logic cpu;
    logic ri;
    logic ov;
    logic bp;
    logic sys;
    logic tr;
    logic adel_ld;
    logic ades;
    logic tlbl_ld;
    logic tlbs;
    logic mod;
  } exception_info_t;

  typedef struct packed {
    logic [5:0] im;
    logic       erl;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  typedef struct packed {
    exc_code_t   code;
    logic [31:0] pc;
    logic [31:0] badvaddr;
    logic        in_delay_slot;
    logic [31:0] location;
  } exception_t;

  typedef enum logic [1:0] {IDLE, REDIRECT, BLANK} arb_state_t;

  function automatic logic is_data_addr_code(exc_code_t c);
    return (c == CODE_ADEL) || (c == CODE_ADES) || (c == CODE_TLBL) ||
           (c == CODE_TLBS) || (c == CODE_MOD);
  endfunction

endpackage

// File: rtl/exception_arbiter_cause.sv
// Single-lane cause priority encoder: combinational, zero latency.
// No backpressure; the refill hint survives only on the TLB miss causes.
module exc_cause_encode
  import exception_arbiter_pkg::*;
(
  input  exception_info_t exc_info,
  input  logic            int_req,
  input  logic            refill_in,
  output logic            hit,
  output exc_code_t       code,
  output logic            refill
);

  always_comb begin
    hit    = 1'b1;
    code   = CODE_INT;
    refill = 1'b0;
    if (int_req)                code = CODE_INT;
    else if (exc_info.adel_if)  code = CODE_ADEL;
    else if (exc_info.tlbl_if) begin
      code   = CODE_TLBL;
      refill = refill_in;
    end
    else if (exc_info.cpu)      code = CODE_CPU;
    else if (exc_info.ri)       code = CODE_RI;
    else if (exc_info.ov)       code = CODE_OV;
    else if (exc_info.bp)       code = CODE_BP;
    else if (exc_info.sys)      code = CODE_SYS;
    else if (exc_info.tr)       code = CODE_TR;
    else if (exc_info.adel_ld)  code = CODE_ADEL;
    else if (exc_info.ades)     code = CODE_ADES;
    else if (exc_info.tlbl_ld) begin
      code   = CODE_TLBL;
      refill = refill_in;
    end
    else if (exc_info.tlbs) begin
      code   = CODE_TLBS;
      refill = refill_in;
    end
    else if (exc_info.mod)      code = CODE_MOD;
    else                        hit  = 1'b0;
  end

endmodule

// File: rtl/exception_arbiter.sv
// Commit-stage arbiter: picks the oldest excepting lane, registers the record 1 cycle after the flag.
// Holds stall until redirect_ready is seen, then one BLANK cycle before commit resumes.
module exception_arbiter
  import exception_arbiter_pkg::*;
#(
  parameter int          LANES        = 2,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] EXC_ENTRY    = 32'hbfc00380,
  parameter logic [31:0] REFILL_ENTRY = 32'hbfc00200
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [5:0]                   ext_int,
  input  logic [LANES-1:0]             lane_valid,
  input  exception_info_t [LANES-1:0]  lane_exc_info,
  input  logic [LANES-1:0]             lane_tlb_refill,
  input  logic [LANES-1:0][31:0]       lane_pc,
  input  logic [LANES-1:0][31:0]       lane_vaddr,
  input  logic [LANES-1:0]             lane_in_delay_slot,
  input  cp0_status_t                  cp0_status,
  input  logic                         redirect_ready,
  output logic [LANES-1:0]             commit_mask,
  output logic                         stall,
  output logic                         exception_valid,
  output exception_t                   exception,
  output logic [31:0]                  pcexception
);

  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic                        int_req;
  logic [LANES-1:0]            lane_int;
  logic [LANES-1:0]            lane_hit;
  logic [LANES-1:0]            lane_refill;
  exc_code_t [LANES-1:0]       lane_code;
  logic                        victim_found;
  logic [LANES-1:0]            mask_idle;
  exception_t                  next_rec;
  exception_t                  exc_q;
  arb_state_t                  state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= ext_int;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign int_req = (|(sync_q[SYNC_STAGES-1] & cp0_status.im)) & cp0_status.ie &
                   ~cp0_status.exl & ~cp0_status.erl;

  // The interrupt is taken on the oldest committing instruction only
  always_comb begin
    logic seen;
    seen     = 1'b0;
    lane_int = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_valid[i] && !seen) begin
        lane_int[i] = int_req;
        seen        = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_enc
    exc_cause_encode u_enc (
      .exc_info  (lane_exc_info[g]),
      .int_req   (lane_int[g]),
      .refill_in (lane_tlb_refill[g]),
      .hit       (lane_hit[g]),
      .code      (lane_code[g]),
      .refill    (lane_refill[g])
    );
  end

  always_comb begin
    victim_found = 1'b0;
    mask_idle    = '0;
    next_rec     = '0;
    for (int i = 0; i < LANES; i++) begin
      mask_idle[i] = lane_valid[i] & ~victim_found;
      if (lane_valid[i] && lane_hit[i] && !victim_found) begin
        victim_found           = 1'b1;
        mask_idle[i]           = 1'b0;
        next_rec.code          = lane_code[i];
        next_rec.pc            = lane_pc[i];
        next_rec.in_delay_slot = lane_in_delay_slot[i];
        next_rec.location      = lane_refill[i] ? REFILL_ENTRY : EXC_ENTRY;
        // Fetch-side faults report the PC; data-side faults report the access address
        if (!lane_int[i] && (lane_exc_info[i].adel_if || lane_exc_info[i].tlbl_if))
          next_rec.badvaddr = lane_pc[i];
        else if (is_data_addr_code(lane_code[i]))
          next_rec.badvaddr = lane_vaddr[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      exception_valid <= 1'b0;
      exc_q           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (victim_found) begin
            exc_q           <= next_rec;
            exception_valid <= 1'b1;
            state           <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            exception_valid <= 1'b0;
            state           <= BLANK;
          end
        end
        BLANK:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    commit_mask = '0;
    if (reset && (state == IDLE)) commit_mask = mask_idle;
  end

  assign stall       = (state != IDLE);
  assign exception   = exc_q;
  assign pcexception = exc_q.location;

endmodule

// File: tb/tb_exception_arbiter.sv
// Bench for exception_arbiter: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic compared against a behavioural model.
module tb_exception_arbiter;
  import exception_arbiter_pkg::*;

  localparam int          LANES = 2;
  localparam int          SS    = 2;
  localparam logic [31:0] EXC   = 32'hbfc00380;
  localparam logic [31:0] REF   = 32'hbfc00200;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic [5:0]                  ext_int = '0;
  logic [LANES-1:0]            lane_valid = '0;
  exception_info_t [LANES-1:0] lane_exc_info = '0;
  logic [LANES-1:0]            lane_tlb_refill = '0;
  logic [LANES-1:0][31:0]      lane_pc = '0;
  logic [LANES-1:0][31:0]      lane_vaddr = '0;
  logic [LANES-1:0]            lane_in_delay_slot = '0;
  cp0_status_t                 cp0_status = '0;
  logic                        redirect_ready = 1'b0;
  logic [LANES-1:0]            commit_mask;
  logic                        stall;
  logic                        exception_valid;
  exception_t                  exception;
  logic [31:0]                 pcexception;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  exception_arbiter #(
    .LANES(LANES), .SYNC_STAGES(SS), .EXC_ENTRY(EXC), .REFILL_ENTRY(REF)
  ) dut (
    .clk(clk), .reset(reset), .ext_int(ext_int), .lane_valid(lane_valid),
    .lane_exc_info(lane_exc_info), .lane_tlb_refill(lane_tlb_refill),
    .lane_pc(lane_pc), .lane_vaddr(lane_vaddr), .lane_in_delay_slot(lane_in_delay_slot),
    .cp0_status(cp0_status), .redirect_ready(redirect_ready),
    .commit_mask(commit_mask), .stall(stall), .exception_valid(exception_valid),
    .exception(exception), .pcexception(pcexception)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic             found;
    exception_t       rec;
    logic [LANES-1:0] mask;
  } ref_t;

  // Cause table in priority order; index 0 is the interrupt
  localparam exc_code_t PRIO_CODE [14] = '{CODE_INT, CODE_ADEL, CODE_TLBL, CODE_CPU, CODE_RI,
    CODE_OV, CODE_BP, CODE_SYS, CODE_TR, CODE_ADEL, CODE_ADES, CODE_TLBL, CODE_TLBS, CODE_MOD};

  int         m_state = 0;   // 0 idle, 1 waiting for fetch, 2 blank cycle
  logic       m_vld = 1'b0;
  exception_t m_rec = '0;
  logic [5:0] hist [SS];
  ref_t       m_r;

  initial for (int i = 0; i < SS; i++) hist[i] = '0;

  function automatic ref_t ref_eval();
    ref_t            r;
    logic            intr;
    int              int_lane;
    logic [13:0]     f;
    int              k;
    exception_info_t x;
    r.found = 1'b0;
    r.rec   = '0;
    r.mask  = '0;
    intr = (|(hist[SS-1] & cp0_status.im)) && cp0_status.ie && !cp0_status.exl && !cp0_status.erl;
    int_lane = -1;
    for (int l = 0; l < LANES; l++) if (lane_valid[l] && int_lane < 0) int_lane = l;
    for (int l = 0; l < LANES; l++) begin
      if (!lane_valid[l] || r.found) continue;
      x = lane_exc_info[l];
      f = {x.mod, x.tlbs, x.tlbl_ld, x.ades, x.adel_ld, x.tr, x.sys, x.bp, x.ov, x.ri,
           x.cpu, x.tlbl_if, x.adel_if, intr && (l == int_lane)};
      if (f == '0) begin
        r.mask[l] = 1'b1;
      end else begin
        k = 0;
        while (!f[k]) k++;
        r.found              = 1'b1;
        r.rec.code           = PRIO_CODE[k];
        r.rec.pc             = lane_pc[l];
        r.rec.in_delay_slot  = lane_in_delay_slot[l];
        r.rec.location       = (lane_tlb_refill[l] && (k == 2 || k == 11 || k == 12)) ? REF : EXC;
        r.rec.badvaddr       = (k == 1 || k == 2) ? lane_pc[l] : (k >= 9 ? lane_vaddr[l] : 32'h0);
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0;
      m_vld   = 1'b0;
      m_rec   = '0;
      for (int i = 0; i < SS; i++) hist[i] = '0;
    end else begin
      m_r = ref_eval();
      case (m_state)
        0: if (m_r.found) begin m_rec = m_r.rec; m_vld = 1'b1; m_state = 1; end
        1: if (redirect_ready) begin m_vld = 1'b0; m_state = 2; end
        default: m_state = 0;
      endcase
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ext_int;
    end
  end

  task automatic check_model(input int n);
    ref_t r;
    r = ref_eval();
    chk($sformatf("rnd%0d_mask", n), commit_mask, (m_state == 0) ? r.mask : '0);
    chk($sformatf("rnd%0d_stall", n), stall, m_state != 0);
    chk($sformatf("rnd%0d_valid", n), exception_valid, m_vld);
    if (m_vld) begin
      chk($sformatf("rnd%0d_code", n), exception.code, m_rec.code);
      chk($sformatf("rnd%0d_pc", n), exception.pc, m_rec.pc);
      chk($sformatf("rnd%0d_bad", n), exception.badvaddr, m_rec.badvaddr);
      chk($sformatf("rnd%0d_ds", n), exception.in_delay_slot, m_rec.in_delay_slot);
      chk($sformatf("rnd%0d_pcexc", n), pcexception, m_rec.location);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]      valid;
    exception_info_t i0, i1;
    logic [1:0]      rf, ds;
    logic [31:0]     pc0, pc1, va0, va1;
    logic [1:0]      e_mask;
    logic            e_exc;
    exc_code_t       e_code;
    logic [31:0]     e_pc, e_bad, e_loc;
    logic            e_ds;
  } vec_t;

  function automatic vec_t mk(logic [1:0] valid, exception_info_t i0, exception_info_t i1,
      logic [1:0] rf, logic [1:0] ds, logic [31:0] pc0, logic [31:0] pc1, logic [31:0] va0,
      logic [31:0] va1, logic [1:0] e_mask, logic e_exc, exc_code_t e_code, logic [31:0] e_pc,
      logic [31:0] e_bad, logic [31:0] e_loc, logic e_ds);
    vec_t v;
    v.valid = valid; v.i0 = i0; v.i1 = i1; v.rf = rf; v.ds = ds;
    v.pc0 = pc0; v.pc1 = pc1; v.va0 = va0; v.va1 = va1;
    v.e_mask = e_mask; v.e_exc = e_exc; v.e_code = e_code;
    v.e_pc = e_pc; v.e_bad = e_bad; v.e_loc = e_loc; v.e_ds = e_ds;
    return v;
  endfunction

  task automatic set_clean(input logic [1:0] valid);
    lane_valid      = valid;
    lane_exc_info   = '0;
    lane_tlb_refill = '0;
  endtask

  localparam int NV = 10;
  vec_t vt [NV];

  initial begin
    exception_info_t f_ri, f_sys, f_adel_ld, f_tlbl_if, f_ov, f_tlbs, f_none;
    logic            seen_vld;
    f_none = '0;
    f_ri = '0;      f_ri.ri = 1'b1;
    f_sys = '0;     f_sys.sys = 1'b1;
    f_adel_ld = '0; f_adel_ld.adel_ld = 1'b1;
    f_tlbl_if = '0; f_tlbl_if.tlbl_if = 1'b1;
    f_ov = '0;      f_ov.ov = 1'b1;
    f_tlbs = '0;    f_tlbs.tlbs = 1'b1;

    //          valid  lane0      lane1   rf     ds     pc0           pc1           va0    va1       mask  exc code       e_pc          e_bad         loc  ds
    vt[0] = mk(2'b11, f_none,    f_ri,   2'b00, 2'b10, 32'h80001000, 32'h80001004, 0,     0,        2'b01, 1, CODE_RI,   32'h80001004, 32'h0,        EXC, 1'b1);
    vt[1] = mk(2'b11, f_adel_ld, f_sys,  2'b00, 2'b00, 32'h80002000, 32'h80002004, 32'h3, 0,        2'b00, 1, CODE_ADEL, 32'h80002000, 32'h3,        EXC, 1'b0);
    vt[2] = mk(2'b01, f_tlbl_if, f_none, 2'b01, 2'b00, 32'h00400000, 0,            0,     0,        2'b00, 1, CODE_TLBL, 32'h00400000, 32'h00400000, REF, 1'b0);
    vt[3] = mk(2'b01, f_tlbl_if, f_none, 2'b00, 2'b00, 32'h00400000, 0,            0,     0,        2'b00, 1, CODE_TLBL, 32'h00400000, 32'h00400000, EXC, 1'b0);
    vt[4] = mk(2'b10, f_ri,      f_ov,   2'b00, 2'b00, 32'h100,      32'h200,      0,     0,        2'b00, 1, CODE_OV,   32'h200,      32'h0,        EXC, 1'b0);
    vt[5] = mk(2'b01, f_ri,      f_none, 2'b01, 2'b01, 32'h500,      0,            0,     0,        2'b00, 1, CODE_RI,   32'h500,      32'h0,        EXC, 1'b1);
    vt[6] = mk(2'b11, f_none,    f_tlbs, 2'b10, 2'b00, 32'h300,      32'h304,      0,     32'h1234, 2'b01, 1, CODE_TLBS, 32'h304,      32'h1234,     REF, 1'b0);
    vt[7] = mk(2'b11, f_none,    f_none, 2'b00, 2'b00, 32'h400,      32'h404,      0,     0,        2'b11, 0, CODE_INT,  0,            0,            0,   1'b0);
    vt[8] = mk(2'b00, f_ri,      f_sys,  2'b00, 2'b00, 32'h600,      32'h604,      0,     0,        2'b00, 0, CODE_INT,  0,            0,            0,   1'b0);
    vt[9] = mk(2'b11, f_sys,     f_ri,   2'b00, 2'b00, 32'h700,      32'h704,      0,     0,        2'b00, 1, CODE_SYS,  32'h700,      32'h0,        EXC, 1'b0);

    // Reset state: lanes present but commit blocked while reset is held
    set_clean(2'b11);
    nxt(); nxt(); #1;
    chk("rst_mask", commit_mask, 2'b00);
    chk("rst_stall", stall, 1'b0);
    chk("rst_valid", exception_valid, 1'b0);
    chk("rst_pcexc", pcexception, 32'h0);
    reset = 1'b1; #1;
    chk("rst_release_mask", commit_mask, 2'b11);

    for (int v = 0; v < NV; v++) begin
      nxt();
      lane_valid = vt[v].valid;
      lane_exc_info[0] = vt[v].i0;  lane_exc_info[1] = vt[v].i1;
      lane_tlb_refill = vt[v].rf;   lane_in_delay_slot = vt[v].ds;
      lane_pc[0] = vt[v].pc0;       lane_pc[1] = vt[v].pc1;
      lane_vaddr[0] = vt[v].va0;    lane_vaddr[1] = vt[v].va1;
      #1;
      chk($sformatf("v%0d_mask", v), commit_mask, vt[v].e_mask);
      nxt();
      set_clean(2'b11);
      #1;
      chk($sformatf("v%0d_valid", v), exception_valid, vt[v].e_exc);
      if (vt[v].e_exc) begin
        chk($sformatf("v%0d_code", v), exception.code, vt[v].e_code);
        chk($sformatf("v%0d_pc", v), exception.pc, vt[v].e_pc);
        chk($sformatf("v%0d_bad", v), exception.badvaddr, vt[v].e_bad);
        chk($sformatf("v%0d_ds", v), exception.in_delay_slot, vt[v].e_ds);
        chk($sformatf("v%0d_loc", v), exception.location, vt[v].e_loc);
        chk($sformatf("v%0d_pcexc", v), pcexception, vt[v].e_loc);
        chk($sformatf("v%0d_redir_stall", v), stall, 1'b1);
        chk($sformatf("v%0d_redir_mask", v), commit_mask, 2'b00);
        redirect_ready = 1'b1;
        nxt();
        redirect_ready = 1'b0;
        #1;
        chk($sformatf("v%0d_blank_stall", v), stall, 1'b1);
        chk($sformatf("v%0d_blank_valid", v), exception_valid, 1'b0);
        chk($sformatf("v%0d_blank_mask", v), commit_mask, 2'b00);
        nxt(); #1;
        chk($sformatf("v%0d_idle_stall", v), stall, 1'b0);
        chk($sformatf("v%0d_idle_mask", v), commit_mask, 2'b11);
      end
    end

    // Interrupt: ext_int[2] -> exception_valid exactly SS+1 edges later
    nxt();
    set_clean(2'b01);
    lane_pc[0] = 32'h80000200;
    cp0_status = '{im: 6'b000100, erl: 1'b0, exl: 1'b0, ie: 1'b1};
    ext_int = 6'b000100;
    nxt(); #1; chk("int_c1_valid", exception_valid, 1'b0);
    nxt(); #1; chk("int_c2_valid", exception_valid, 1'b0);
    chk("int_c2_mask", commit_mask, 2'b00);
    nxt(); #1; chk("int_c3_valid", exception_valid, 1'b1);
    chk("int_code", exception.code, CODE_INT);
    chk("int_pc", exception.pc, 32'h80000200);
    chk("int_pcexc", pcexception, EXC);
    ext_int = '0; set_clean(2'b00); redirect_ready = 1'b1;
    nxt(); redirect_ready = 1'b0;
    nxt(); nxt();

    // Same interrupt with EXL set: never taken
    cp0_status.exl = 1'b1;
    set_clean(2'b01);
    ext_int = 6'b000100;
    seen_vld = 1'b0;
    for (int c = 0; c < 6; c++) begin
      nxt(); #1;
      seen_vld |= exception_valid;
    end
    chk("int_exl_valid", seen_vld, 1'b0);
    chk("int_exl_mask", commit_mask, 2'b01);
    ext_int = '0; cp0_status = '0;
    nxt(); nxt(); nxt();

    // Fetch holds off the redirect for several cycles
    lane_exc_info[0] = f_ri;
    lane_pc[0] = 32'h80000100;
    nxt();
    set_clean(2'b11);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("hold%0d_stall", k), stall, 1'b1);
      chk($sformatf("hold%0d_valid", k), exception_valid, 1'b1);
      chk($sformatf("hold%0d_pc", k), exception.pc, 32'h80000100);
      chk($sformatf("hold%0d_code", k), exception.code, CODE_RI);
      nxt();
    end
    redirect_ready = 1'b1;
    nxt();
    redirect_ready = 1'b0;
    #1;
    chk("hold_blank_stall", stall, 1'b1);
    chk("hold_blank_valid", exception_valid, 1'b0);
    nxt(); #1;
    chk("hold_idle_stall", stall, 1'b0);
    chk("hold_idle_mask", commit_mask, 2'b11);

    // Reset asserted while waiting for fetch
    nxt();
    set_clean(2'b01);
    lane_exc_info[0] = f_ri;
    nxt();
    set_clean(2'b01);
    #1;
    chk("rstmid_pre_valid", exception_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk("rstmid_valid", exception_valid, 1'b0);
    chk("rstmid_stall", stall, 1'b0);
    chk("rstmid_mask", commit_mask, 2'b00);
    chk("rstmid_pc", exception.pc, 32'h0);
    nxt(); nxt();
    reset = 1'b1;
    #1;
    chk("rstmid_rel_mask", commit_mask, 2'b01);
    nxt(); #1;
    chk("rstmid_rel_valid", exception_valid, 1'b0);
    chk("rstmid_rel_stall", stall, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      nxt();
      lane_valid = LANES'($urandom);
      for (int l = 0; l < LANES; l++) begin
        lane_exc_info[l] = ($urandom_range(0, 2) == 0) ? exception_info_t'($urandom & $urandom & $urandom) : '0;
        lane_pc[l] = $urandom;
        lane_vaddr[l] = $urandom;
      end
      lane_tlb_refill = LANES'($urandom);
      lane_in_delay_slot = LANES'($urandom);
      ext_int = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'h0;
      cp0_status = cp0_status_t'($urandom);
      cp0_status.ie = ($urandom_range(0, 3) != 0);
      cp0_status.exl = ($urandom_range(0, 3) == 0);
      cp0_status.erl = ($urandom_range(0, 7) == 0);
      redirect_ready = 1'($urandom);
      #1;
      check_model(n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exception_arbiter.md
Name: exception_arbiter

Overview:
- Multi-lane successor to the single-lane exception unit.
- Sits at the commit stage of the superscalar in-order pipeline and takes LANES parallel commit slots (lane 0 is oldest).
- Synchronises external interrupts, selects the oldest excepting lane, and resolves its priority-encoded cause.
- Registers a precise exception record, then holds the fetch redirect through a ready/valid handshake before commit resumes.

Parameters:
- LANES, 2: number of commit lanes; legal range 1..4.
- SYNC_STAGES, 2: flop stages on ext_int; legal range 1..3.
- EXC_ENTRY, 32'hbfc00380: general exception vector.
- REFILL_ENTRY, 32'hbfc00200: TLB-refill vector.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ext_int  in  6  raw external interrupt lines
- lane_valid  in  LANES  slot holds a committing instruction
- lane_exc_info  in  LANES x exception_info_t  per-lane exception flags
- lane_tlb_refill  in  LANES  TLB miss is a refill
- lane_pc  in  LANES x 32  instruction PC
- lane_vaddr  in  LANES x 32  faulting address
- lane_in_delay_slot  in  LANES  instruction is in a delay slot
- cp0_status  in  cp0_status_t  IE/EXL/ERL/IM
- redirect_ready  in  1  fetch accepts the redirect
- commit_mask  out  LANES  lanes allowed to retire this cycle
- stall  out  1  commit must hold
- exception_valid  out  1  registered exception record valid
- exception  out  exception_t  code, pc, badvaddr, in_delay_slot, location
- pcexception  out  32  redirect target

Behaviour:
- Interrupt sync:
  - ext_int passes through SYNC_STAGES flops, reset to 0.
  - int_req = |(sync_int & IM) & IE & ~EXL & ~ERL.
  - int_req attaches only to the lowest-index valid lane.
- Per-lane cause priority, highest first: INT, ADEL(instr), TLBL(instr), CPU, RI, OF, BP, SYS, TR, ADEL(load), ADES, TLBL(load), TLBS, MOD.
- tlb_refill is honoured only for the three TLB causes.
- Selection: the victim is the lowest-index lane that is valid and has (|exc_info or attached int).
- commit_mask in IDLE:
  - bit i = lane_valid[i] & (i < victim).
  - With no victim, commit_mask = lane_valid.
  - Lanes with lane_valid=0 are ignored, even if their flags are set.
- FSM states: IDLE, REDIRECT, BLANK.
  - IDLE, victim found: latch record, exception_valid<=1 next cycle, go to REDIRECT.
  - REDIRECT: exception and pcexception stay stable; stall=1; commit_mask=0. Leave only when redirect_ready=1 on a clock edge, then go to BLANK and drop exception_valid on that edge.
  - BLANK: one cycle with stall=1 and commit_mask=0 so CP0 EXL can update; then IDLE.
  - REDIRECT with redirect_ready=1 on its first cycle: still spends exactly one cycle in REDIRECT.
- Latency:
  - Exception flag to exception_valid: 1 cycle.
  - ext_int rising to exception_valid: SYNC_STAGES+1 cycles minimum, given a valid lane and unmasked status.
- Simultaneous events:
  - New lane exceptions or interrupts during REDIRECT/BLANK are not sampled; the pipeline holds them because stall=1.
  - Interrupt and synchronous exception on the same lane: INT wins.
- pcexception = REFILL_ENTRY if the latched refill bit is set, else EXC_ENTRY; exception.location is the same value.
- Reset (async, active-low), including mid-REDIRECT:
  - FSM to IDLE; exception_valid=0; exception record='0; sync flops=0.
  - stall=0; commit_mask follows lane_valid combinationally once out of reset.
  - While reset is asserted, commit_mask=0.

Decomposition:
- mips.svh/package holds exception_info_t, exception_t, exc_code_t, cp0_status_t, and the CODE_* constants.
- Add a new typedef arb_state_t {IDLE, REDIRECT, BLANK} to the package.
- One sub-module, exc_cause_encode: combinational, single-lane priority encoder returning {hit, code, tlb_refill}; instantiated LANES times in a generate loop.

Test Plan:
- LANES=2: lane0 clean, lane1 exc_info.ri, pc1=0x80001004 -> commit_mask=2'b01; next cycle exception_valid=1, code=RI, pc=0x80001004, pcexception=0xbfc00380.
- Both lanes set, lane0 load ADEL vaddr=0x3, lane1 sys -> victim lane0, commit_mask=00, code=ADEL, badvaddr=0x3.
- lane0 instr_tlb with lane_tlb_refill=1 -> pcexception=0xbfc00200; repeat with refill=0 -> 0xbfc00380.
- ext_int[2]=1, IM[2]=1, IE=1, EXL=0, lane0 valid -> exception_valid exactly 3 cycles later (SYNC_STAGES=2), code=INT; repeat with EXL=1 -> no exception.
- Hold redirect_ready=0 for 5 cycles -> record stable and stall=1 throughout; ready=1 -> BLANK for 1 cycle, then IDLE with stall=0.
- Drop reset in REDIRECT -> exception_valid=0 asynchronously; after release, FSM is in IDLE and a clean lane commits on the first cycle.
